// File: rtl/fsm_seq_ctrl_if.sv
// Control/result bundle between a run requester and the fsm stimulus sequencer.
// Trace vectors are present only when FSM_SEQ_TRACE_EN is defined.
interface fsm_seq_ctrl_if #(
  parameter int LEN   = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [LEN-1:0]   pattern;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hits1;
  logic [CNT_W-1:0] hits2;
`ifdef FSM_SEQ_TRACE_EN
  logic [LEN-1:0]   trace1;
  logic [LEN-1:0]   trace2;
`endif

  modport master (
    output start, pattern, len,
`ifdef FSM_SEQ_TRACE_EN
    input  trace1, trace2,
`endif
    input  busy, done, hits1, hits2
  );

  modport slave (
    input  start, pattern, len,
`ifdef FSM_SEQ_TRACE_EN
    output trace1, trace2,
`endif
    output busy, done, hits1, hits2
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Serial stimulus sequencer and hit counter for the single-input two-output fsm.
// Optional sample trace registers are enabled by defining FSM_SEQ_TRACE_EN.
module fsm_seq_ctrl #(
  parameter int LEN       = 8,
  parameter int CNT_W     = 4,
  parameter int DRAIN_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  fsm_seq_ctrl_if.slave bus,
  output logic          fsm_a,
  input  logic          fsm_out1,
  input  logic          fsm_out2
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t           state, state_d;
  logic [LEN-1:0]   pat_q;
  logic [CNT_W-1:0] eff_len_q;
  logic [CNT_W-1:0] eff_len_in;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] hits1_q, hits2_q;
  logic             sampling;
  logic             accept;

  assign eff_len_in = (bus.len > CNT_W'(LEN)) ? CNT_W'(LEN) : bus.len;
  assign accept     = (state == IDLE) && bus.start;
  assign sampling   = (state == DRIVE) || (state == DRAIN);

  assign bus.busy  = sampling;
  assign bus.done  = (state == DONE);
  assign bus.hits1 = hits1_q;
  assign bus.hits2 = hits2_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (bus.start) state_d = (eff_len_in == '0) ? DONE : DRIVE;
      DRIVE: if (idx == eff_len_q - CNT_W'(1)) state_d = DRAIN;
      DRAIN: if (drain_cnt == CNT_W'(DRAIN_CYC - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pat_q holds the bits still to be driven, so the next fsm_a bit is always pat_q[0]
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_a     <= 1'b0;
      pat_q     <= '0;
      eff_len_q <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      hits1_q   <= '0;
      hits2_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          fsm_a <= 1'b0;
          if (bus.start) begin
            pat_q     <= bus.pattern >> 1;
            eff_len_q <= eff_len_in;
            idx       <= '0;
            drain_cnt <= '0;
            hits1_q   <= '0;
            hits2_q   <= '0;
            fsm_a     <= (eff_len_in != '0) && bus.pattern[0];
          end
        end
        DRIVE: begin
          idx   <= idx + CNT_W'(1);
          pat_q <= pat_q >> 1;
          fsm_a <= (state_d == DRIVE) ? pat_q[0] : 1'b0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + CNT_W'(1);
          fsm_a     <= 1'b0;
        end
        default: fsm_a <= 1'b0;
      endcase

      if (sampling) begin
        if (fsm_out1 && (hits1_q != '1)) hits1_q <= hits1_q + CNT_W'(1);
        if (fsm_out2 && (hits2_q != '1)) hits2_q <= hits2_q + CNT_W'(1);
      end
    end
  end

`ifdef FSM_SEQ_TRACE_EN
  logic [LEN-1:0] trace1_q, trace2_q;

  assign bus.trace1 = trace1_q;
  assign bus.trace2 = trace2_q;

  // Newest sample enters at bit 0, so the MSB is the oldest of the last LEN samples
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      trace1_q <= '0;
      trace2_q <= '0;
    end else if (sampling) begin
      trace1_q <= {trace1_q[LEN-2:0], fsm_out1};
      trace2_q <= {trace2_q[LEN-2:0], fsm_out2};
    end
  end
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed self-checking bench for fsm_seq_ctrl; define FSM_SEQ_TRACE_EN to also
// exercise the trace registers.
module tb_fsm_seq_ctrl;
  localparam int LEN       = 8;
  localparam int CNT_W     = 4;
  localparam int DRAIN_CYC = 1;

  logic clk = 1'b0;
  logic reset;
  logic fsm_a;
  logic fsm_out1, fsm_out2;
  int   passed = 0;
  int   total  = 0;

  fsm_seq_ctrl_if #(.LEN(LEN), .CNT_W(CNT_W)) bus();

  fsm_seq_ctrl #(.LEN(LEN), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .fsm_a(fsm_a),
    .fsm_out1(fsm_out1),
    .fsm_out2(fsm_out2)
  );

  always #5 clk = ~clk;

  // Each tick lands 1 time unit after a rising edge, i.e. at the start of the next cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.pattern = '0; bus.len = '0;
    fsm_out1 = 1'b0; fsm_out2 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({fsm_a, bus.busy, bus.done, bus.hits1, bus.hits2} !== 11'b0) begin
        $display("[TB] FAIL reset_idle c=%0d a=%b busy=%b done=%b h1=%0d h2=%0d exp all 0",
                 c, fsm_a, bus.busy, bus.done, bus.hits1, bus.hits2);
      end else passed++;
    end
  endtask

  task automatic test_basic;
    logic [6:0] ea = 7'b0001110;
    logic [6:0] eb = 7'b0111111;
    logic [6:0] ed = 7'b1000000;
    bus.pattern = 8'b0000_1110; bus.len = 4'd5;
    fsm_out1 = 1'b1; fsm_out2 = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      total++;
      if ({fsm_a, bus.busy, bus.done} !== {ea[c-1], eb[c-1], ed[c-1]}) begin
        $display("[TB] FAIL basic_seq c=%0d got a/busy/done=%b%b%b exp %b%b%b",
                 c, fsm_a, bus.busy, bus.done, ea[c-1], eb[c-1], ed[c-1]);
      end else passed++;
    end
    total++;
    if ({bus.hits1, bus.hits2} !== {4'd6, 4'd0}) begin
      $display("[TB] FAIL basic_hits got h1=%0d h2=%0d exp 6 0", bus.hits1, bus.hits2);
    end else passed++;
    tick();
    total++;
    if ({bus.busy, bus.done, bus.hits1} !== {1'b0, 1'b0, 4'd6}) begin
      $display("[TB] FAIL basic_hold got busy=%b done=%b h1=%0d exp 0 0 6",
               bus.busy, bus.done, bus.hits1);
    end else passed++;
  endtask

  task automatic test_clamp;
    logic [7:0] ea = 8'b1010_0101;
    logic       exp_a;
    bus.pattern = 8'b1010_0101; bus.len = 4'd15;
    fsm_out1 = 1'b1; fsm_out2 = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      exp_a = (c <= 8) ? ea[c-1] : 1'b0;
      total++;
      if ({fsm_a, bus.busy, bus.done} !== {exp_a, (c <= 9), (c == 10)}) begin
        $display("[TB] FAIL clamp_seq c=%0d got a/busy/done=%b%b%b exp %b%b%b",
                 c, fsm_a, bus.busy, bus.done, exp_a, (c <= 9), (c == 10));
      end else passed++;
    end
    total++;
    if ({bus.hits1, bus.hits2} !== {4'd9, 4'd9}) begin
      $display("[TB] FAIL clamp_hits got h1=%0d h2=%0d exp 9 9", bus.hits1, bus.hits2);
    end else passed++;
    tick();
  endtask

  task automatic test_zero_len;
    bus.pattern = 8'hFF; bus.len = 4'd0;
    fsm_out1 = 1'b1; fsm_out2 = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.done, bus.busy, fsm_a, bus.hits1, bus.hits2} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("[TB] FAIL zero_len_c1 got done=%b busy=%b a=%b h1=%0d h2=%0d exp 1 0 0 0 0",
               bus.done, bus.busy, fsm_a, bus.hits1, bus.hits2);
    end else passed++;
    tick();
    total++;
    if ({bus.done, bus.busy, fsm_a} !== 3'b000) begin
      $display("[TB] FAIL zero_len_c2 got done=%b busy=%b a=%b exp 0 0 0",
               bus.done, bus.busy, fsm_a);
    end else passed++;
  endtask

  task automatic test_ignored_start;
    logic [6:0] ea = 7'b0001110;
    logic [6:0] eb = 7'b0111111;
    logic [6:0] ed = 7'b1000000;
    bus.pattern = 8'b0000_1110; bus.len = 4'd5;
    fsm_out1 = 1'b1; fsm_out2 = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin bus.start = 1'b0; bus.pattern = 8'hFF; bus.len = 4'd8; end
      if (c == 2) bus.start = 1'b1;
      if (c == 3) bus.start = 1'b0;
      if (c == 7) bus.start = 1'b1;
      total++;
      if ({fsm_a, bus.busy, bus.done} !== {ea[c-1], eb[c-1], ed[c-1]}) begin
        $display("[TB] FAIL ignore_seq c=%0d got a/busy/done=%b%b%b exp %b%b%b",
                 c, fsm_a, bus.busy, bus.done, ea[c-1], eb[c-1], ed[c-1]);
      end else passed++;
    end
    total++;
    if (bus.hits1 !== 4'd6) begin
      $display("[TB] FAIL ignore_hits got h1=%0d exp 6", bus.hits1);
    end else passed++;
    tick();
    bus.start = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.done, bus.hits1} !== {1'b0, 1'b0, 4'd6}) begin
      $display("[TB] FAIL ignore_done_start got busy=%b done=%b h1=%0d exp 0 0 6",
               bus.busy, bus.done, bus.hits1);
    end else passed++;
  endtask

  task automatic test_reset_mid;
    bus.pattern = 8'hFF; bus.len = 4'd8;
    fsm_out1 = 1'b1; fsm_out2 = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      total++;
      if ({fsm_a, bus.busy} !== 2'b11) begin
        $display("[TB] FAIL rmid_run c=%0d got a=%b busy=%b exp 1 1", c, fsm_a, bus.busy);
      end else passed++;
    end
    total++;
    if (bus.hits1 !== 4'd2) begin
      $display("[TB] FAIL rmid_hits_c3 got h1=%0d exp 2", bus.hits1);
    end else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({fsm_a, bus.busy, bus.done, bus.hits1, bus.hits2} !== 11'b0) begin
      $display("[TB] FAIL rmid_c4 got a=%b busy=%b done=%b h1=%0d h2=%0d exp all 0",
               fsm_a, bus.busy, bus.done, bus.hits1, bus.hits2);
    end else passed++;
    for (int c = 5; c <= 14; c++) begin
      tick();
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        $display("[TB] FAIL rmid_quiet c=%0d got busy=%b done=%b exp 0 0",
                 c, bus.busy, bus.done);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] ea = 9'b001000010;
    logic [8:0] eb = 9'b011100111;
    logic [8:0] ed = 9'b100001000;
    bus.pattern = 8'b0000_0010; bus.len = 4'd2;
    fsm_out1 = 1'b0; fsm_out2 = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 6) bus.start = 1'b0;
      total++;
      if ({fsm_a, bus.busy, bus.done} !== {ea[c-1], eb[c-1], ed[c-1]}) begin
        $display("[TB] FAIL b2b_seq c=%0d got a/busy/done=%b%b%b exp %b%b%b",
                 c, fsm_a, bus.busy, bus.done, ea[c-1], eb[c-1], ed[c-1]);
      end else passed++;
      if (c == 5 || c == 6 || c == 9) begin
        total++;
        if (bus.hits2 !== ((c == 6) ? 4'd0 : 4'd3)) begin
          $display("[TB] FAIL b2b_hits2 c=%0d got %0d exp %0d",
                   c, bus.hits2, (c == 6) ? 0 : 3);
        end else passed++;
      end
    end
    total++;
    if (bus.hits1 !== 4'd0) begin
      $display("[TB] FAIL b2b_hits1 got %0d exp 0", bus.hits1);
    end else passed++;
    tick();
  endtask

`ifdef FSM_SEQ_TRACE_EN
  task automatic test_trace;
    logic [5:0] s1 = 6'b001101;
    bus.pattern = 8'b0000_1110; bus.len = 4'd5;
    fsm_out1 = 1'b0; fsm_out2 = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.start = 1'b0;
      fsm_out1 = (c <= 6) ? s1[c-1] : 1'b0;
    end
    total++;
    if ({bus.trace1, bus.trace2} !== {8'b0010_1100, 8'b0}) begin
      $display("[TB] FAIL trace got t1=%b t2=%b exp 00101100 00000000",
               bus.trace1, bus.trace2);
    end else passed++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting fsm_seq_ctrl bench");
    test_reset();
    test_basic();
    test_clamp();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
`ifdef FSM_SEQ_TRACE_EN
    test_trace();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
